// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter_pkg
//  Purpose  : Shared widths, memory command encoding, requester identity and
//             tag-table entry layout for the LSU/IF memory port arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

  // Bus widths are fixed for the whole slice so the interface, the arbiter
  // and the tag table always agree.
  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 64;
  localparam int MEM_TAG_W = 4;
  localparam int NUM_TAGS  = 1 << MEM_TAG_W;

  // Command presented to the memory model.
  typedef enum logic [1:0] {
    MEM_NONE  = 2'b00,
    MEM_LOAD  = 2'b01,
    MEM_STORE = 2'b10
  } mem_cmd_e;

  // Which requester a response belongs to.
  typedef enum logic {
    OWNER_LSU = 1'b0,
    OWNER_IF  = 1'b1
  } owner_e;

  // One outstanding-tag record. A stale entry still occupies its tag until
  // the memory answers, but its data is dropped.
  typedef struct packed {
    logic   valid;
    owner_e owner;
    logic   stale;
  } mem_tag_entry_t;

  // An entry whose response should be delivered to its owner.
  function automatic logic entry_live(input mem_tag_entry_t e);
    return e.valid && !e.stale;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter_if
//  Purpose  : Bundles the LSU, instruction-fetch and memory-side signals of
//             the shared memory port. The slave modport is the arbiter's
//             view; the master modport is the surrounding pipeline/memory.
//  Revision : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
  ();

  // LSU side
  logic              ls_req;
  logic              ls_is_store;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic              ls_ack;
  logic              ls_rvalid;
  logic [DATA_W-1:0] ls_rdata;

  // Instruction-fetch side
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  // Memory side
  mem_cmd_e             proc2mem_command;
  logic [ADDR_W-1:0]    proc2mem_addr;
  logic [DATA_W-1:0]    proc2mem_data;
  logic [MEM_TAG_W-1:0] mem2proc_response;
  logic [MEM_TAG_W-1:0] mem2proc_tag;
  logic [DATA_W-1:0]    mem2proc_data;

  // Arbiter view
  modport slave (
    input  ls_req, ls_is_store, ls_addr, ls_wdata,
    output ls_ack, ls_rvalid, ls_rdata,
    input  if_req, if_addr,
    output if_ack, if_rvalid, if_rdata,
    output proc2mem_command, proc2mem_addr, proc2mem_data,
    input  mem2proc_response, mem2proc_tag, mem2proc_data
  );

  // Pipeline + memory view
  modport master (
    output ls_req, ls_is_store, ls_addr, ls_wdata,
    input  ls_ack, ls_rvalid, ls_rdata,
    output if_req, if_addr,
    input  if_ack, if_rvalid, if_rdata,
    input  proc2mem_command, proc2mem_addr, proc2mem_data,
    output mem2proc_response, mem2proc_tag, mem2proc_data
  );

endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter_mem_tag_table.sv
`default_nettype none
// ============================================================================
//  Module   : mem_tag_table
//  Purpose  : Registered table of outstanding memory tags. One allocate port,
//             one retire/lookup port (combinational lookup, clear on the next
//             edge) and a bulk stale-mark used on pipeline flush.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_tag_table
  import mem_port_arbiter_pkg::*;
(
  input  wire logic                 clk,
  input  wire logic                 reset,
  input  wire logic                 flush,
  input  wire logic                 i_alloc_en,
  input  wire logic [MEM_TAG_W-1:0] i_alloc_tag,
  input  wire owner_e               i_alloc_owner,
  input  wire logic [MEM_TAG_W-1:0] i_lookup_tag,
  output      logic                 o_hit,
  output      owner_e               o_hit_owner
);

  mem_tag_entry_t r_table [NUM_TAGS];
  mem_tag_entry_t w_next  [NUM_TAGS];
  mem_tag_entry_t w_lookup;
  logic           w_retire;

  // Tag 0 is never a real response, so it neither hits nor retires.
  assign w_retire    = (i_lookup_tag != '0);
  assign w_lookup    = r_table[i_lookup_tag];
  assign o_hit       = w_retire && entry_live(w_lookup);
  assign o_hit_owner = w_lookup.owner;

  for (genvar gi = 0; gi < NUM_TAGS; gi++) begin : g_entry
    // Next-state per entry: flush marks stale, retire clears, allocate last so it wins.
    always_comb begin
      w_next[gi] = r_table[gi];
      if (flush && r_table[gi].valid) begin
        w_next[gi].stale = 1'b1;
      end
      if (w_retire && (i_lookup_tag == MEM_TAG_W'(gi))) begin
        w_next[gi] = '0;
      end
      if (i_alloc_en && (i_alloc_tag == MEM_TAG_W'(gi))) begin
        w_next[gi].valid = 1'b1;
        w_next[gi].owner = i_alloc_owner;
        w_next[gi].stale = flush;
      end
    end
  end

  // Table storage; reset forgets every outstanding tag.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_TAGS; i++) begin
        r_table[i] <= '0;
      end
    end else begin
      r_table <= w_next;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Shares one tagged memory port between the LSU and instruction
//             fetch. LSU has priority; a starvation counter forces IF to win
//             after STARVE_LIMIT consecutive denials. Responses are routed
//             back to the owner recorded for their tag.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input wire logic          clk,
  input wire logic          reset,
  input wire logic          flush,
  mem_port_arbiter_if.slave bus
);

  localparam int               CNT_W        = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] C_STARVE_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] r_starve_cnt;
  logic             w_if_win;
  logic             w_ls_win;
  logic             w_accepted;
  logic             w_alloc_en;
  owner_e           w_alloc_owner;
  logic             w_hit;
  owner_e           w_hit_owner;
  logic             w_ls_rvalid;
  logic             w_if_rvalid;

  // Grant: IF only beats a requesting LSU once it has been starved long enough.
  assign w_if_win   = bus.if_req && (!bus.ls_req || (r_starve_cnt == C_STARVE_MAX));
  assign w_ls_win   = bus.ls_req && !w_if_win;
  assign w_accepted = (bus.mem2proc_response != '0);

  assign bus.ls_ack = w_ls_win && w_accepted;
  assign bus.if_ack = w_if_win && w_accepted;

  // Winner drives the memory port; store data only travels with a store.
  always_comb begin
    bus.proc2mem_command = MEM_NONE;
    bus.proc2mem_addr    = '0;
    bus.proc2mem_data    = '0;
    if (w_if_win) begin
      bus.proc2mem_command = MEM_LOAD;
      bus.proc2mem_addr    = bus.if_addr;
    end else if (w_ls_win) begin
      bus.proc2mem_addr = bus.ls_addr;
      if (bus.ls_is_store) begin
        bus.proc2mem_command = MEM_STORE;
        bus.proc2mem_data    = bus.ls_wdata;
      end else begin
        bus.proc2mem_command = MEM_LOAD;
      end
    end
  end

  // Stores get no data response, so only accepted loads/fetches own a tag.
  assign w_alloc_en    = w_accepted && (w_if_win || (w_ls_win && !bus.ls_is_store));
  assign w_alloc_owner = w_if_win ? OWNER_IF : OWNER_LSU;

  // Count consecutive IF denials, saturating at the limit; flush does not touch it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_starve_cnt <= '0;
    end else if (!bus.if_req || bus.if_ack) begin
      r_starve_cnt <= '0;
    end else if (r_starve_cnt != C_STARVE_MAX) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

  mem_tag_table u_tag_table (
    .clk           (clk),
    .reset         (reset),
    .flush         (flush),
    .i_alloc_en    (w_alloc_en),
    .i_alloc_tag   (bus.mem2proc_response),
    .i_alloc_owner (w_alloc_owner),
    .i_lookup_tag  (bus.mem2proc_tag),
    .o_hit         (w_hit),
    .o_hit_owner   (w_hit_owner)
  );

  // Response routing with zero added latency; rdata is forced to 0 when not valid.
  assign w_ls_rvalid   = w_hit && (w_hit_owner == OWNER_LSU);
  assign w_if_rvalid   = w_hit && (w_hit_owner == OWNER_IF);
  assign bus.ls_rvalid = w_ls_rvalid;
  assign bus.if_rvalid = w_if_rvalid;
  assign bus.ls_rdata  = w_ls_rvalid ? bus.mem2proc_data : '0;
  assign bus.if_rdata  = w_if_rvalid ? bus.mem2proc_data : '0;

endmodule
`default_nettype wire
